// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_pkg
// Purpose  : Shared constants and types for the comparator datapath.
// Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

  localparam int CMP_WIDTH = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cmp_state_t;

endpackage
`default_nettype wire

// File: rtl/operand_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : operand_deserializer
// Purpose  : Assembles LSB-first serial operand pairs into a registered a/b slot
//            with valid/ready handshake and sticky overrun detection.
// Revision : 1.0 - initial release
// ============================================================================
module operand_deserializer
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_start,
  input  logic             bit_a,
  input  logic             bit_b,
  input  logic             pair_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             pair_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  cmp_state_t       r_state;
  cmp_state_t       w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] w_sh_a_next;
  logic [WIDTH-1:0] w_sh_b_next;
  logic             r_done;
  logic             w_done_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_pair_valid;
  logic             r_overrun;
  logic             w_xfer;
  logic             w_slot_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_sh_a  <= w_sh_a_next;
      r_sh_b  <= w_sh_b_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_sh_a_next  = r_sh_a;
    w_sh_b_next  = r_sh_b;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bit_valid && bit_start) begin
          w_sh_a_next[0] = bit_a;
          w_sh_b_next[0] = bit_b;
          w_count_next   = CNT_W'(1);
          w_state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (bit_start) begin
            // A fresh start mid-frame silently abandons the partial frame
            w_sh_a_next[0] = bit_a;
            w_sh_b_next[0] = bit_b;
            w_count_next   = CNT_W'(1);
          end else begin
            for (int i = 0; i < WIDTH; i++) begin
              if (r_count == CNT_W'(i)) begin
                w_sh_a_next[i] = bit_a;
                w_sh_b_next[i] = bit_b;
              end
            end
            if (r_count == CNT_W'(WIDTH - 1)) begin
              w_done_next  = 1'b1;
              w_count_next = '0;
              w_state_next = IDLE;
            end else begin
              w_count_next = r_count + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_count_next = '0;
      end
    endcase
  end

  assign w_xfer      = r_pair_valid & pair_ready;
  assign w_slot_free = ~r_pair_valid | pair_ready;

  // Output slot: r_done lags the last beat by one edge, giving the 1-cycle latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_pair_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (r_done && w_slot_free) begin
        r_a          <= r_sh_a;
        r_b          <= r_sh_b;
        r_pair_valid <= 1'b1;
      end else if (w_xfer) begin
        r_pair_valid <= 1'b0;
      end

      if (r_done && !w_slot_free) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign a          = r_a;
  assign b          = r_b;
  assign pair_valid = r_pair_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_state == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_operand_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_deserializer
// Purpose  : Directed and randomized self-checking bench for operand_deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_deserializer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         bit_valid;
  logic         bit_start;
  logic         bit_a;
  logic         bit_b;
  logic         pair_ready;
  logic         overrun_clr;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         pair_valid;
  logic         overrun;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference slot state, tracked as plain integers
  int m_valid;
  int m_a;
  int m_b;
  int m_ovr;

  operand_deserializer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_valid   (bit_valid),
    .bit_start   (bit_start),
    .bit_a       (bit_a),
    .bit_b       (bit_b),
    .pair_ready  (pair_ready),
    .overrun_clr (overrun_clr),
    .a           (a),
    .b           (b),
    .pair_valid  (pair_valid),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic s, input logic ba, input logic bb);
    bit_valid = 1'b1;
    bit_start = s;
    bit_a     = ba;
    bit_b     = bb;
    tick();
    bit_valid = 1'b0;
    bit_start = 1'b0;
  endtask

  task automatic send_frame(input int av, input int bv, input int gap);
    for (int i = 0; i < W; i++) begin
      beat(i == 0, av[i], bv[i]);
      if (i < W - 1) repeat (gap) tick();
    end
  endtask

  task automatic chk_slot(input string tag, input int v, input int ea, input int eb, input int eo);
    chk({tag, "_valid"}, 32'(pair_valid), 32'(v));
    if (v != 0) begin
      chk({tag, "_a"}, 32'(a), 32'(ea));
      chk({tag, "_b"}, 32'(b), 32'(eb));
    end
    chk({tag, "_ovr"}, 32'(overrun), 32'(eo));
  endtask

  initial begin
    rst = 1'b1; bit_valid = 1'b0; bit_start = 1'b0; bit_a = 1'b0; bit_b = 1'b0;
    pair_ready = 1'b0; overrun_clr = 1'b0;
    #12;
    chk("rst_a", 32'(a), 0);
    chk("rst_b", 32'(b), 0);
    chk("rst_valid", 32'(pair_valid), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic frame 5/3, consumed as soon as it appears
    pair_ready = 1'b1;
    send_frame(5, 3, 0);
    chk("basic_latency_valid", 32'(pair_valid), 0);
    tick();
    chk_slot("basic", 1, 5, 3, 0);
    tick();
    chk("basic_consumed", 32'(pair_valid), 0);

    // Gapped frame: busy must hold across idle cycles
    beat(1'b1, 1'b1, 1'b1);
    chk("gap_busy0", 32'(busy), 1);
    tick();
    chk("gap_busy1", 32'(busy), 1);
    tick();
    chk("gap_busy2", 32'(busy), 1);
    beat(1'b0, 1'b0, 1'b1);
    beat(1'b0, 1'b1, 1'b0);
    chk("gap_idle_after", 32'(busy), 0);
    tick();
    chk_slot("gap", 1, 5, 3, 0);
    tick();

    // Overrun: second frame dropped while first is held
    pair_ready = 1'b0;
    send_frame(5, 3, 0);
    tick();
    chk_slot("ovr_first", 1, 5, 3, 0);
    send_frame(2, 7, 0);
    tick();
    chk_slot("ovr_second", 1, 5, 3, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk_slot("ovr_clr", 1, 5, 3, 0);

    // Completion coinciding with transfer of the held 5/3
    send_frame(6, 1, 0);
    chk_slot("simul_before", 1, 5, 3, 0);
    pair_ready = 1'b1;
    tick();
    chk_slot("simul", 1, 6, 1, 0);
    tick();
    chk("simul_drain", 32'(pair_valid), 0);

    // Restart mid-frame: only the restarted frame appears
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b1);
    beat(1'b1, 4 & 1, 4 & 1);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_novalid", 32'(pair_valid), 0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b1);
    tick();
    chk_slot("restart", 1, 4, 4, 0);
    tick();
    chk("restart_drain", 32'(pair_valid), 0);

    // Asynchronous reset during beat 2 with a held pair and overrun set
    pair_ready = 1'b0;
    send_frame(5, 3, 0);
    tick();
    send_frame(2, 7, 0);
    tick();
    chk_slot("pre_rst", 1, 5, 3, 1);
    beat(1'b1, 1'b1, 1'b1);
    bit_valid = 1'b1; bit_a = 1'b0; bit_b = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("async_a", 32'(a), 0);
    chk("async_b", 32'(b), 0);
    chk("async_valid", 32'(pair_valid), 0);
    chk("async_ovr", 32'(overrun), 0);
    chk("async_busy", 32'(busy), 0);
    tick();
    bit_valid = 1'b0;
    rst = 1'b0;
    bit_valid = 1'b1; bit_a = 1'b1; bit_b = 1'b0;
    tick();
    bit_valid = 1'b0;
    repeat (3) tick();
    chk("post_rst_valid", 32'(pair_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // Randomized frames against the integer slot model
    m_valid = 0; m_a = 0; m_b = 0; m_ovr = 0;
    for (int n = 0; n < 40; n++) begin
      int av, bv, gap, r;
      av  = int'($urandom_range((1 << W) - 1, 0));
      bv  = int'($urandom_range((1 << W) - 1, 0));
      gap = int'($urandom_range(2, 0));
      r   = int'($urandom_range(1, 0));
      pair_ready = r[0];
      // With ready high the held pair drains on the first edge of the frame
      if (r != 0) m_valid = 0;
      send_frame(av, bv, gap);
      tick();
      if (m_valid == 0 || r != 0) begin
        m_valid = 1; m_a = av; m_b = bv;
      end else begin
        m_ovr = 1;
      end
      chk_slot("rand_done", m_valid, m_a, m_b, m_ovr);
      tick();
      if (r != 0) m_valid = 0;
      chk("rand_after", 32'(pair_valid), 32'(m_valid));
      if ($urandom_range(3, 0) == 0) begin
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        if (r != 0) m_valid = 0;
        m_ovr = 0;
        chk("rand_clr", 32'(overrun), 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_deserializer.md
Name: operand_deserializer

Overview:
- Upstream feeder for the 3-bit comparator stage.
- Receives operand pairs A and B serially, LSB first, one bit of each per beat.
- Assembles each pair into parallel WIDTH-bit words and presents them on the comparator's a/b inputs with a valid/ready handshake.
- Decouples assembly from consumption so the next frame can shift in while the current pair is held.

Parameters:
- WIDTH, 3, operand width in bits; must be >= 2.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bit_valid  in  1  serial beat qualifier.
- bit_start  in  1  first beat of a frame; only meaningful when bit_valid=1.
- bit_a  in  1  serial bit of operand A, LSB first.
- bit_b  in  1  serial bit of operand B, LSB first.
- pair_ready  in  1  downstream (comparator/capture) accepts the pair.
- overrun_clr  in  1  clears the sticky overrun flag.
- a  out  WIDTH  parallel operand A to comparator.
- b  out  WIDTH  parallel operand B to comparator.
- pair_valid  out  1  a/b hold a complete, unconsumed pair.
- overrun  out  1  sticky: a completed frame was dropped.
- busy  out  1  a frame is partially shifted in.

Behaviour:
- Reset is asynchronous and active-high on rst; single clock clk. Reset values: a=0, b=0, pair_valid=0, overrun=0, busy=0, FSM=IDLE, beat count=0, shift registers=0.
- Assertion of rst mid-frame discards the partial frame and the held pair immediately, without waiting for a clock edge.
- FSM has two states:
  - IDLE: bit_valid & bit_start loads bit 0 of A/B and sets count=1. Goes to SHIFT (WIDTH>=2). bit_valid without bit_start is ignored.
  - SHIFT: each bit_valid beat writes bit[count] and increments count. Beats with bit_valid=0 stall with no state change. On the beat where count reaches WIDTH-1, the frame completes and the FSM returns to IDLE.
  - bit_start with bit_valid while in SHIFT aborts the partial frame and restarts it: the beat is bit 0, count=1. No flag is raised.
- busy = (state==SHIFT).
- Output slot: a/b/pair_valid are registered separately from the shift registers.
- Completion latency: last beat at edge t, so pair_valid=1 and a/b updated after edge t+1, i.e. one cycle after the last bit is sampled.
- Handshake: a transfer occurs when pair_valid & pair_ready at an edge. While pair_valid=1 and no transfer occurs, a/b are stable. pair_ready is ignored when pair_valid=0.
- Frame completion is handled according to the slot state:
  - Slot empty, or slot transferring in the same cycle: load the new pair, pair_valid=1. On simultaneous completion and transfer, pair_valid stays high with the new data and there are no bubbles.
  - Slot full and not transferring: the new frame is dropped, overrun=1, and a/b keep the old pair.
- overrun is sticky until overrun_clr=1 at an edge. If overrun_clr and a new overrun occur in the same cycle, the set wins and overrun=1.
- No combinational path from any input to any output; all outputs are registered.
- Width rules: beat count is $clog2(WIDTH) bits, no wrap beyond WIDTH-1. Bit i of the frame goes to a[i]/b[i].

Decomposition:
- Shared package cmp_pkg holds:
  - CMP_WIDTH constant (3), used by this block and the comparator.
  - The state typedef: enum logic {IDLE, SHIFT}.
- No sub-module; shift registers, counter and output slot stay inline in one module.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> a=0, b=0, pair_valid=0, overrun=0, busy=0 immediately.
2. Basic frame, A=5, B=3, WIDTH=3: beats (a,b)=(1,1) with start, then (0,1), then (1,0), consecutive, pair_ready=1 -> pair_valid high one cycle after the 3rd beat with a=3'b101, b=3'b011, then low the next cycle.
3. Gapped beats: same frame with bit_valid=0 for 2 cycles between beats 1 and 2 -> identical a/b, and busy=1 throughout the gap.
4. Overrun: pair_ready=0; frame A=5,B=3, then frame A=2,B=7 -> overrun=1 after the 2nd frame and a/b stay 5/3. Pulse overrun_clr -> overrun=0.
5. Simultaneous complete and consume: hold pair 5/3 and assert pair_ready exactly on the cycle frame A=6,B=1 completes -> pair_valid stays 1, a/b=6/1, overrun=0.
6. Restart and reset mid-frame:
   - Two beats of frame X, then start of frame A=4,B=4 -> result 4/4 only.
   - rst during beat 2 of any frame -> no pair_valid is produced from that frame.
